switch_traffic_stats: RTL

Parametrised, synthesizable per-port traffic statistics unit for the N-port packet switch. It observes each ingress port's valid/target/FIFO-full signals and each egress port's valid, and keeps saturating counters of accepted, dropped and delivered traffic plus a global in-flight balance. Drops are weighted by target fan-out. Counters are read back through a one-cycle request/response port, so integrity accounting keeps working in gate-level/SDF runs where internal FIFO probes are unavailable.

---
 rtl/switch_traffic_stats_if.sv | 33 +++
 rtl/switch_traffic_stats.sv | 134 +++++++++++++
 2 files changed

// File: rtl/switch_traffic_stats_if.sv
// Observation and read-back bundle for the switch traffic statistics unit.
// The switch/testbench side is the master; the statistics block is the slave.
interface switch_traffic_stats_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned SEL_WIDTH = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]           valid_in;
    logic [NUM_PORTS*NUM_PORTS-1:0] target_in;
    logic [NUM_PORTS-1:0]           fifo_full;
    logic [NUM_PORTS-1:0]           valid_out;
    logic                           freeze;
    logic                           clear;
    logic                           rd_req;
    logic [SEL_WIDTH-1:0]           rd_sel;
    logic [1:0]                     rd_kind;
    logic                           rd_valid;
    logic [CNT_WIDTH-1:0]           rd_data;
    logic                           sat_flag;
    logic                           underflow_err;

    modport master (
        output valid_in, target_in, fifo_full, valid_out, freeze, clear,
               rd_req, rd_sel, rd_kind,
        input  rd_valid, rd_data, sat_flag, underflow_err
    );

    modport slave (
        input  valid_in, target_in, fifo_full, valid_out, freeze, clear,
               rd_req, rd_sel, rd_kind,
        output rd_valid, rd_data, sat_flag, underflow_err
    );
endinterface

// File: rtl/switch_traffic_stats.sv
// Per-port saturating accepted/dropped/delivered counters, global in-flight
// balance and sticky error flags, read back through a one-cycle request port.
module switch_traffic_stats #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned SEL_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    switch_traffic_stats_if.slave bus
);
    localparam int unsigned WW = $clog2(NUM_PORTS + 1);
    localparam int unsigned SW = CNT_WIDTH + WW + 1;
    localparam int unsigned DW = CNT_WIDTH + 3;
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;

    logic [CNT_WIDTH-1:0] acc_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0] drp_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0] dlv_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0] ifl_q;
    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic                 sat_q;
    logic                 udf_q;

    logic [WW-1:0]        w_c       [NUM_PORTS];
    logic [WW-1:0]        acc_inc_c [NUM_PORTS];
    logic [WW-1:0]        drp_inc_c [NUM_PORTS];
    logic [CNT_WIDTH:0]   acc_r_c   [NUM_PORTS];
    logic [CNT_WIDTH:0]   drp_r_c   [NUM_PORTS];
    logic [CNT_WIDTH:0]   dlv_r_c   [NUM_PORTS];
    logic [DW-1:0]        acc_sum_c;
    logic [DW-1:0]        dlv_sum_c;
    logic [DW-1:0]        ifl_sum_c;
    logic [CNT_WIDTH-1:0] ifl_base_c;
    logic [CNT_WIDTH-1:0] ifl_nxt_c;
    logic                 sat_evt_c;
    logic                 udf_evt_c;
    logic [CNT_WIDTH-1:0] rd_mux_c;

    // Returns {clamped, value}; the counter sticks at all-ones.
    function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic [WW-1:0] inc);
        logic [SW-1:0] sum;
        sum = SW'(base) + SW'(inc);
        if (sum > SW'(CMAX)) sat_add = {1'b1, CMAX};
        else                 sat_add = {1'b0, sum[CNT_WIDTH-1:0]};
    endfunction

    // Next counter values; on clear each counter restarts from this cycle's increment.
    always_comb begin
        sat_evt_c  = 1'b0;
        udf_evt_c  = 1'b0;
        acc_sum_c  = '0;
        dlv_sum_c  = '0;
        ifl_base_c = bus.clear ? '0 : ifl_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_c[i] = '0;
            for (int unsigned b = 0; b < NUM_PORTS; b++)
                w_c[i] = w_c[i] + WW'(bus.target_in[i*NUM_PORTS + b]);
            acc_inc_c[i] = (bus.valid_in[i] & ~bus.fifo_full[i]) ? w_c[i] : '0;
            drp_inc_c[i] = (bus.valid_in[i] &  bus.fifo_full[i]) ? w_c[i] : '0;
            acc_r_c[i] = sat_add(bus.clear ? '0 : acc_q[i], acc_inc_c[i]);
            drp_r_c[i] = sat_add(bus.clear ? '0 : drp_q[i], drp_inc_c[i]);
            dlv_r_c[i] = sat_add(bus.clear ? '0 : dlv_q[i], WW'(bus.valid_out[i]));
            sat_evt_c  = sat_evt_c | acc_r_c[i][CNT_WIDTH] | drp_r_c[i][CNT_WIDTH]
                                   | dlv_r_c[i][CNT_WIDTH];
            acc_sum_c  = acc_sum_c + DW'(acc_inc_c[i]);
            dlv_sum_c  = dlv_sum_c + DW'(bus.valid_out[i]);
        end
        // Two's-complement delta; the top bit is the sign of the new balance.
        ifl_sum_c = DW'(ifl_base_c) + acc_sum_c - dlv_sum_c;
        if (ifl_sum_c[DW-1]) begin
            ifl_nxt_c = '0;
            udf_evt_c = 1'b1;
        end else if (ifl_sum_c > DW'(CMAX)) begin
            ifl_nxt_c = CMAX;
            sat_evt_c = 1'b1;
        end else begin
            ifl_nxt_c = ifl_sum_c[CNT_WIDTH-1:0];
        end
    end

    // Read mux over pre-update values; out-of-range port selects read as zero.
    always_comb begin
        rd_mux_c = '0;
        if (bus.rd_kind == 2'd3) begin
            rd_mux_c = ifl_q;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (bus.rd_sel == SEL_WIDTH'(i)) begin
                    case (bus.rd_kind)
                        2'd0:    rd_mux_c = acc_q[i];
                        2'd1:    rd_mux_c = drp_q[i];
                        default: rd_mux_c = dlv_q[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                acc_q[i] <= '0;
                drp_q[i] <= '0;
                dlv_q[i] <= '0;
            end
            ifl_q      <= '0;
            sat_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (bus.clear || !bus.freeze) begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    acc_q[i] <= acc_r_c[i][CNT_WIDTH-1:0];
                    drp_q[i] <= drp_r_c[i][CNT_WIDTH-1:0];
                    dlv_q[i] <= dlv_r_c[i][CNT_WIDTH-1:0];
                end
                ifl_q <= ifl_nxt_c;
                sat_q <= bus.clear ? 1'b0 : (sat_q | sat_evt_c);
                udf_q <= bus.clear ? 1'b0 : (udf_q | udf_evt_c);
            end
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) rd_data_q <= rd_mux_c;
        end
    end

    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.sat_flag      = sat_q;
    assign bus.underflow_err = udf_q;
endmodule
